// File: rtl/axilite_ram_slave_pkg.sv
// Shared definitions for the AXI4-Lite RAM slave and its master: bus widths
// and the write/read FSM state encodings.
package axilite_ram_slave_pkg;

  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;
  localparam int unsigned AxiStrbW = AxiDataW / 8;

  typedef enum logic [1:0] {
    StWCollect = 2'd0,
    StWWait    = 2'd1,
    StWResp    = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    StRIdle = 2'd0,
    StRWait = 2'd1,
    StRData = 2'd2
  } r_state_e;

  // Counter width that stays legal when the count is 0 or 1.
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/axilite_ram_array.sv
// Word-organised RAM: one byte-enabled write port, one registered read port.
// Contents are not reset; only the read data register is.
module axilite_ram_array
  import axilite_ram_slave_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned IdxW  = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [IdxW-1:0]     waddr_i,
  input  logic [AxiDataW-1:0] wdata_i,
  input  logic [AxiStrbW-1:0] wstrb_i,
  input  logic                re_i,
  input  logic [IdxW-1:0]     raddr_i,
  output logic [AxiDataW-1:0] rdata_o
);

  logic [AxiDataW-1:0] mem_q [Depth];
  logic [AxiDataW-1:0] rdata_q;

  // Byte-enabled write; a zero strobe leaves the word untouched.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < int'(AxiStrbW); i++) begin
        if (wstrb_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Registered read; a same-edge write is not visible (read-before-write).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axilite_ram_slave.sv
// AXI4-Lite RAM slave with independent write and read FSMs.
// Optional feature macro: AXILITE_RAM_WAIT_STATES_EN adds WAIT_CYCLES of
// response latency on each channel (WAIT_CYCLES=0 behaves as disabled).
module axilite_ram_slave
  import axilite_ram_slave_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [AxiAddrW-1:0] axi_awaddr,
  input  logic [2:0]          axi_awprot,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  input  logic [AxiDataW-1:0] axi_wdata,
  input  logic [AxiStrbW-1:0] axi_wstrb,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  input  logic [AxiAddrW-1:0] axi_araddr,
  input  logic [2:0]          axi_arprot,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic [AxiDataW-1:0] axi_rdata
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  w_state_e            w_state_q, w_state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [IdxW-1:0]     awidx_q, awidx_d;
  logic [AxiDataW-1:0] wdata_q, wdata_d;
  logic [AxiStrbW-1:0] wstrb_q, wstrb_d;
  logic                w_commit;

  r_state_e            r_state_q, r_state_d;
  logic                ar_done_q, ar_done_d;
  logic [IdxW-1:0]     aridx_q, aridx_d;
  logic                r_sample;

`ifdef AXILITE_RAM_WAIT_STATES_EN
  localparam bit          WaitEn  = (WAIT_CYCLES != 0);
  localparam int unsigned CntW    = clog2_min1(WAIT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);
  logic [CntW-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
`endif

  // Protection bits, sub-word and aliasing address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr, axi_araddr, 32'(WAIT_CYCLES)};

  // Write FSM: collect AW and W independently, commit on entry to response.
  always_comb begin
    w_state_d   = w_state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awidx_d     = awidx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    w_commit    = 1'b0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
`ifdef AXILITE_RAM_WAIT_STATES_EN
    w_cnt_d     = w_cnt_q;
`endif
    unique case (w_state_q)
      StWCollect: begin
        axi_awready = !aw_done_q;
        axi_wready  = !w_done_q;
        if (axi_awvalid && !aw_done_q) begin
          aw_done_d = 1'b1;
          awidx_d   = axi_awaddr[IdxW+1:2];
        end
        if (axi_wvalid && !w_done_q) begin
          w_done_d = 1'b1;
          wdata_d  = axi_wdata;
          wstrb_d  = axi_wstrb;
        end
        if (aw_done_q && w_done_q) begin
`ifdef AXILITE_RAM_WAIT_STATES_EN
          if (WaitEn) begin
            w_state_d = StWWait;
            w_cnt_d   = '0;
          end else begin
            w_state_d = StWResp;
            w_commit  = 1'b1;
          end
`else
          w_state_d = StWResp;
          w_commit  = 1'b1;
`endif
        end
      end
      StWWait: begin
`ifdef AXILITE_RAM_WAIT_STATES_EN
        if (w_cnt_q == CntLast) begin
          w_state_d = StWResp;
          w_commit  = 1'b1;
        end else begin
          w_cnt_d = w_cnt_q + 1'b1;
        end
`else
        w_state_d = StWCollect;
`endif
      end
      StWResp: begin
        axi_bvalid = 1'b1;
        if (axi_bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = StWCollect;
        end
      end
      default: w_state_d = StWCollect;
    endcase
  end

  // Read FSM: capture AR, sample the array on entry to the data phase.
  always_comb begin
    r_state_d   = r_state_q;
    ar_done_d   = ar_done_q;
    aridx_d     = aridx_q;
    r_sample    = 1'b0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
`ifdef AXILITE_RAM_WAIT_STATES_EN
    r_cnt_d     = r_cnt_q;
`endif
    unique case (r_state_q)
      StRIdle: begin
        axi_arready = !ar_done_q;
        if (axi_arvalid && !ar_done_q) begin
          ar_done_d = 1'b1;
          aridx_d   = axi_araddr[IdxW+1:2];
        end
        if (ar_done_q) begin
          ar_done_d = 1'b0;
`ifdef AXILITE_RAM_WAIT_STATES_EN
          if (WaitEn) begin
            r_state_d = StRWait;
            r_cnt_d   = '0;
          end else begin
            r_state_d = StRData;
            r_sample  = 1'b1;
          end
`else
          r_state_d = StRData;
          r_sample  = 1'b1;
`endif
        end
      end
      StRWait: begin
`ifdef AXILITE_RAM_WAIT_STATES_EN
        if (r_cnt_q == CntLast) begin
          r_state_d = StRData;
          r_sample  = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + 1'b1;
        end
`else
        r_state_d = StRIdle;
`endif
      end
      StRData: begin
        axi_rvalid = 1'b1;
        if (axi_rready) begin
          r_state_d = StRIdle;
        end
      end
      default: r_state_d = StRIdle;
    endcase
  end

  // Control state with synchronous reset; an in-flight transaction is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= StWCollect;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_state_q <= StRIdle;
      ar_done_q <= 1'b0;
`ifdef AXILITE_RAM_WAIT_STATES_EN
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      r_state_q <= r_state_d;
      ar_done_q <= ar_done_d;
`ifdef AXILITE_RAM_WAIT_STATES_EN
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
`endif
    end
  end

  // Captured address/data payload; qualified by the done flags, so no reset.
  always_ff @(posedge clk) begin
    awidx_q <= awidx_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    aridx_q <= aridx_d;
  end

  // Reset on the commit edge must keep an uncommitted write out of memory.
  axilite_ram_array #(
    .Depth (DEPTH_WORDS),
    .IdxW  (IdxW)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (w_commit && rst_n),
    .waddr_i (awidx_q),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .re_i    (r_sample),
    .raddr_i (aridx_q),
    .rdata_o (axi_rdata)
  );

endmodule

// File: tb/tb_axilite_ram_slave.sv
// Self-checking bench for axilite_ram_slave against a word-array model.
module tb_axilite_ram_slave;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Wait  = 3;
`ifdef AXILITE_RAM_WAIT_STATES_EN
  localparam int ExpLat = 1 + int'(Wait);
`else
  localparam int ExpLat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [Depth];

  always #5 clk = ~clk;

  axilite_ram_slave #(
    .DEPTH_WORDS (Depth),
    .WAIT_CYCLES (Wait)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_awaddr  (axi_awaddr),
    .axi_awprot  (axi_awprot),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_arprot  (axi_arprot),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rdata   (axi_rdata)
  );

  function automatic int widx(logic [31:0] a);
    return int'((a / 4) % Depth);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // All driver tasks start and end just after a falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic axi_write_req(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output int lat, output bit ok);
    int guard;
    bit aw_f, w_f;
    ok = 1'b1;
    lat = -1;
    axi_awaddr = addr; axi_awprot = 3'($urandom); axi_wdata = data; axi_wstrb = strb;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    guard = 0;
    while ((axi_awvalid || axi_wvalid) && guard < 50) begin
      aw_f = axi_awvalid && axi_awready;
      w_f  = axi_wvalid && axi_wready;
      step();
      if (aw_f) axi_awvalid = 1'b0;
      if (w_f)  axi_wvalid  = 1'b0;
      guard++;
    end
    if (axi_awvalid || axi_wvalid) begin
      axi_awvalid = 1'b0; axi_wvalid = 1'b0; ok = 1'b0;
      return;
    end
    lat = 0;
    while (!axi_bvalid && lat < 50) begin step(); lat++; end
    if (!axi_bvalid) ok = 1'b0;
  endtask

  task automatic axi_b_ack();
    axi_bready = 1'b1; step(); axi_bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output int lat, output bit ok);
    axi_write_req(addr, data, strb, lat, ok);
    if (ok) axi_b_ack();
  endtask

  task automatic axi_read_req(input logic [31:0] addr, output logic [31:0] data,
                              output int lat, output bit ok);
    int guard;
    bit ar_f;
    ok = 1'b1; lat = -1; data = '0;
    axi_araddr = addr; axi_arprot = 3'($urandom); axi_arvalid = 1'b1;
    guard = 0;
    while (axi_arvalid && guard < 50) begin
      ar_f = axi_arready;
      step();
      if (ar_f) axi_arvalid = 1'b0;
      guard++;
    end
    if (axi_arvalid) begin axi_arvalid = 1'b0; ok = 1'b0; return; end
    lat = 0;
    while (!axi_rvalid && lat < 50) begin step(); lat++; end
    if (!axi_rvalid) begin ok = 1'b0; return; end
    data = axi_rdata;
  endtask

  task automatic axi_r_ack();
    axi_rready = 1'b1; step(); axi_rready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output int lat, output bit ok);
    axi_read_req(addr, data, lat, ok);
    if (ok) axi_r_ack();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    axi_awvalid = 0; axi_wvalid = 0; axi_bready = 0; axi_arvalid = 0; axi_rready = 0;
    axi_awaddr = 0; axi_awprot = 0; axi_wdata = 0; axi_wstrb = 0; axi_araddr = 0;
    axi_arprot = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    vectors++;
    if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_ready: got %b exp 111", {axi_awready, axi_wready, axi_arready});
    end
    vectors++;
    if ({axi_bvalid, axi_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_valid: got %b exp 00", {axi_bvalid, axi_rvalid});
    end
    vectors++;
    if (axi_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h exp 00000000", axi_rdata);
    end
  endtask

  task automatic test_basic();
    int lat; bit ok; logic [31:0] d;
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, lat, ok);
    model[widx(32'h10)] = 32'hDEADBEEF;
    vectors++;
    if (!ok || lat !== ExpLat) begin
      miscompares++; $display("FAIL basic_b_latency: got %0d exp %0d", lat, ExpLat);
    end
    vectors++;
    if ({axi_awready, axi_wready} !== 2'b11) begin
      miscompares++; $display("FAIL basic_b2b_ready: got %b exp 11", {axi_awready, axi_wready});
    end
    axi_read(32'h10, d, lat, ok);
    vectors++;
    if (!ok || lat !== ExpLat) begin
      miscompares++; $display("FAIL basic_r_latency: got %0d exp %0d", lat, ExpLat);
    end
    vectors++;
    if (d !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL basic_rdata: got %h exp DEADBEEF", d);
    end
    vectors++;
    if (axi_arready !== 1'b1) begin
      miscompares++; $display("FAIL basic_b2b_arready: got %b exp 1", axi_arready);
    end
  endtask

  task automatic test_strobe();
    int lat; bit ok; logic [31:0] d;
    axi_write(32'h10, 32'h000000AA, 4'h1, lat, ok);
    model[widx(32'h10)] = merge(model[widx(32'h10)], 32'h000000AA, 4'h1);
    axi_read(32'h10, d, lat, ok);
    vectors++;
    if (!ok || d !== 32'hDEADBEAA) begin
      miscompares++; $display("FAIL strobe_byte0: got %h exp DEADBEAA", d);
    end
    axi_write(32'h10, 32'hFFFFFFFF, 4'h0, lat, ok);
    axi_read(32'h10, d, lat, ok);
    vectors++;
    if (!ok || d !== model[widx(32'h10)]) begin
      miscompares++; $display("FAIL strobe_zero: got %h exp %h", d, model[widx(32'h10)]);
    end
  endtask

  task automatic test_w_before_aw();
    int lat; bit ok; logic [31:0] d;
    axi_awaddr = 32'h30; axi_wdata = 32'h12345678; axi_wstrb = 4'hF;
    axi_wvalid = 1'b1;
    step();
    axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({axi_wready, axi_awready, axi_bvalid} !== 3'b010) begin
        miscompares++;
        $display("FAIL w_first_hold%0d: got wready/awready/bvalid=%b exp 010", i,
                 {axi_wready, axi_awready, axi_bvalid});
      end
      if (i < 2) step();
    end
    axi_awvalid = 1'b1;
    step();
    axi_awvalid = 1'b0;
    lat = 0;
    while (!axi_bvalid && lat < 50) begin step(); lat++; end
    vectors++;
    if (lat !== ExpLat) begin
      miscompares++; $display("FAIL w_first_b_latency: got %0d exp %0d", lat, ExpLat);
    end
    if (axi_bvalid) axi_b_ack();
    model[widx(32'h30)] = 32'h12345678;
    axi_read(32'h30, d, lat, ok);
    vectors++;
    if (!ok || d !== 32'h12345678) begin
      miscompares++; $display("FAIL w_first_data: got %h exp 12345678", d);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit ok; logic [31:0] d, exp_d;
    exp_d = $urandom;
    axi_write_req(32'h40, exp_d, 4'hF, lat, ok);
    model[widx(32'h40)] = exp_d;
    axi_awaddr = 32'h44; axi_wdata = 32'h5555AAAA; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({axi_bvalid, axi_awready, axi_wready} !== 3'b100) begin
        miscompares++;
        $display("FAIL bp_write%0d: got bvalid/awready/wready=%b exp 100", i,
                 {axi_bvalid, axi_awready, axi_wready});
      end
      step();
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    if (axi_bvalid) axi_b_ack();
    axi_read_req(32'h40, d, lat, ok);
    axi_araddr = 32'h44; axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (!ok || {axi_rvalid, axi_arready} !== 2'b10 || axi_rdata !== exp_d) begin
        miscompares++;
        $display("FAIL bp_read%0d: got rvalid/arready=%b rdata=%h exp 10 %h", i,
                 {axi_rvalid, axi_arready}, axi_rdata, exp_d);
      end
      step();
    end
    axi_arvalid = 1'b0;
    if (axi_rvalid) axi_r_ack();
  endtask

  task automatic test_alias();
    int lat; bit ok; logic [31:0] d, exp_d;
    exp_d = $urandom;
    axi_write(32'h1004, exp_d, 4'hF, lat, ok);
    model[widx(32'h1004)] = exp_d;
    axi_read(32'h4, d, lat, ok);
    vectors++;
    if (!ok || d !== model[1]) begin
      miscompares++; $display("FAIL alias_read: got %h exp %h", d, model[1]);
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit ok; logic [31:0] d;
    axi_write(32'h20, 32'hCAFEF00D, 4'hF, lat, ok);
    model[widx(32'h20)] = 32'hCAFEF00D;
    axi_awaddr = 32'h20; axi_wdata = 32'h0BADF00D; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    step();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    rst_n = 1'b0;
    step();
    vectors++;
    if ({axi_bvalid, axi_awready, axi_wready, axi_arready} !== 4'b0111) begin
      miscompares++;
      $display("FAIL abort_outputs: got bvalid/aw/w/ar=%b exp 0111",
               {axi_bvalid, axi_awready, axi_wready, axi_arready});
    end
    rst_n = 1'b1;
    step();
    axi_read(32'h20, d, lat, ok);
    vectors++;
    if (!ok || d !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL abort_memory: got %h exp CAFEF00D", d);
    end
  endtask

  task automatic test_fill();
    int lat; bit ok; logic [31:0] d;
    for (int i = 0; i < int'(Depth); i++) begin
      d = $urandom;
      axi_write(32'(i * 4), d, 4'hF, lat, ok);
      model[i] = d;
      vectors++;
      if (!ok || lat !== ExpLat) begin
        miscompares++; $display("FAIL fill_%0d: latency got %0d exp %0d", i, lat, ExpLat);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit ok; logic [31:0] a, d, r; logic [3:0] s;
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, lat, ok);
        model[widx(a)] = merge(model[widx(a)], d, s);
        vectors++;
        if (!ok || lat !== ExpLat) begin
          miscompares++; $display("FAIL rand_wr_%0d: latency got %0d exp %0d", n, lat, ExpLat);
        end
      end else begin
        axi_read(a, r, lat, ok);
        vectors++;
        if (!ok || r !== model[widx(a)]) begin
          miscompares++;
          $display("FAIL rand_rd_%0d: addr %h got %h exp %h", n, a, r, model[widx(a)]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_concurrent();
    int lat_w, lat_r, lat; bit ok_w, ok_r, ok; logic [31:0] a, d, r, old_v, after;
    logic [3:0] s;
    for (int n = 0; n < 8; n++) begin
      a = $urandom; d = $urandom; s = 4'($urandom_range(15, 1));
      old_v = model[widx(a)];
      fork
        axi_write(a, d, s, lat_w, ok_w);
        axi_read(a, r, lat_r, ok_r);
      join
      model[widx(a)] = merge(old_v, d, s);
      vectors++;
      if (!ok_w || !ok_r || r !== old_v) begin
        miscompares++; $display("FAIL rbw_%0d: got %h exp %h", n, r, old_v);
      end
      axi_read(a, after, lat, ok);
      vectors++;
      if (!ok || after !== model[widx(a)]) begin
        miscompares++; $display("FAIL rbw_after_%0d: got %h exp %h", n, after, model[widx(a)]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_backpressure();
    test_alias();
    test_reset_abort();
    test_fill();
    test_random();
    test_back_to_back_concurrent();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
